hdlverifier_trigger_sequencer: RTL and testbench
================================================

Name: hdlverifier_trigger_sequencer

Overview:
- Multi-stage trigger sequencer feeding the capture core's trigger input.
- Consumes per-stage match pulses from external comparators and walks a programmable sequence of up to 15 stages, each needing a programmed hit count.
- Emits a one-cycle trigger on completion, plus live status (current_stage, stage_reset, seq_reset) for the capture status register.
- Sits in the clk domain; configuration comes from the synchronized trigger_setting fields.

Parameters:
- NUM_STAGES, 4: implemented stages, 1..15.
- COUNT_WIDTH, 8: width of each stage's hit-count target.
- TIMEOUT_WIDTH, 16: width of the per-stage timeout counter.

Ports:
- clk  input  1  capture clock.
- reset  input  1  synchronous, active-high; clears all state.
- clk_enable  input  1  qualifies all evaluation; state frozen when low.
- start  input  1  arm request; rising edge arms the sequence.
- stage_hit  input  NUM_STAGES  per-stage comparator match, bit n = stage n.
- cfg_last_stage  input  4  index of final stage, clamped to NUM_STAGES-1.
- cfg_count  input  NUM_STAGES*COUNT_WIDTH  hit target per stage, stage n at [n*COUNT_WIDTH +: COUNT_WIDTH].
- cfg_consecutive  input  NUM_STAGES  1 = hits must be back-to-back, 0 = cumulative.
- cfg_timeout  input  TIMEOUT_WIDTH  enabled cycles allowed per stage after stage 0; 0 = disabled.
- trigger  output  1  one-cycle pulse when the final stage completes.
- current_stage  output  4  stage under evaluation.
- stage_reset  output  4  index of the last stage whose count was cleared by a broken consecutive run.
- seq_reset  output  1  sticky: a timeout returned the sequence to stage 0.
- armed  output  1  high while in ARMED.

Behaviour:
- Reset state: state=IDLE. trigger=0, current_stage=0, stage_reset=0, seq_reset=0, armed=0. Hit counter and timeout counter = 0.
- start_d1 is registered every clk, independent of clk_enable. arm_evt = start & ~start_d1.
- States:
  - IDLE: arm_evt -> ARMED, with stage=0, counters=0, stage_reset=0, seq_reset=0.
  - ARMED: evaluates on clk_enable cycles only.
  - DONE: holds current_stage at the final stage index, armed=0. arm_evt -> ARMED with the same clears as from IDLE.
- arm_evt in any state, including mid-ARMED, re-arms from stage 0. It takes priority over all same-cycle evaluation.
- ARMED evaluation each enabled cycle, for s = current stage:
  - Effective target: tgt = (cfg_count[s]==0) ? 1 : cfg_count[s].
  - stage_hit[s]=1: cnt+1. If cnt+1 == tgt, the stage completes.
  - Completion with s < last: stage <= s+1, cnt <= 0, timeout counter <= 0. Advances exactly one stage per cycle; the hit is consumed.
  - Completion with s == last: trigger=1 for exactly one clk next cycle, state -> DONE.
  - stage_hit[s]=0, cfg_consecutive[s]=1, cnt != 0: cnt <= 0, stage_reset <= s. Stage does not change.
  - stage_hit[s]=0 with cumulative mode: no change.
- Latency: the cycle of the final qualifying hit is N; trigger is high in cycle N+1.
- Timeout:
  - Active only for s>0 with cfg_timeout != 0. Counter increments on every enabled ARMED cycle in which the stage does not complete.
  - Counter reaching cfg_timeout: stage <= 0, cnt <= 0, counter <= 0, seq_reset <= 1. seq_reset stays high until the next arm.
  - Completion and timeout in the same cycle: completion wins.
- Counter width: cnt never exceeds tgt, so there is no wrap. tgt = 2^COUNT_WIDTH-1 is legal.
- cfg_* changes while ARMED take effect on the next enabled cycle. Software must only change them while idle or DONE.
- Synchronous reset mid-operation returns to IDLE next clk with all outputs at reset values. Any pending trigger is dropped.

Optional Feature:
- Macro: HDLV_TRIG_SEQ_TIMEOUT_EN.
- Defined: timeout counter and seq_reset logic are built as described.
- Undefined: no timeout counter, cfg_timeout ignored, seq_reset tied 0, and stages wait indefinitely.

Decomposition:
- Package hdlverifier_trigger_pkg holds:
  - state encoding: IDLE=2'd0, ARMED=2'd1, DONE=2'd2.
  - MAX_STAGES=15.
  - STAGE_IDX_W=4.
  - a count-field extraction function.
- One natural sub-module, hdlverifier_trig_timeout_counter: load/clear/enable/expire. Instantiated only under the macro.

Test Plan:
- NUM_STAGES=4, cfg_last_stage=1, cfg_count={3,2}, cumulative mode. Arm; 3 hits on bit0 with gaps, then 2 hits on bit1 -> current_stage goes 0->1 after the 3rd hit; trigger pulses once, 1 clk after the 5th hit; state DONE.
- cfg_consecutive[0]=1, cfg_count[0]=4. Hits 1,1,0,1,1,1,1 -> stage_reset=0 after the gap; stage advances only after the final 4 consecutive hits.
- Macro defined, cfg_timeout=5. Complete stage 0, then no hits for 5 enabled cycles -> current_stage=0, seq_reset=1; next arm clears seq_reset.
- clk_enable toggling 50% during a count target of 3 -> hits with clk_enable=0 are ignored; trigger occurs only after 3 enabled hits.
- Re-arm (start low then high) mid-stage 2 -> next cycle current_stage=0 with counters cleared. Separately, reset asserted in the same cycle as the final hit -> no trigger pulse.
- cfg_count[0]=0 and cfg_last_stage=0 -> a single hit triggers; cfg_last_stage=9 with NUM_STAGES=4 is clamped to 3.

Source files
------------

// File: rtl/hdlverifier_trigger_pkg.sv
// Shared definitions for the multi-stage trigger sequencer: state encoding,
// stage limits and the helper that pulls one stage's hit target out of the
// flattened configuration vector.
package hdlverifier_trigger_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DONE  = 2'd2
   } seq_state_t;

   localparam int MAX_STAGES  = 15;
   localparam int STAGE_IDX_W = 4;
   localparam int MAX_COUNT_W = 32;
   localparam int CFG_FLAT_W  = MAX_STAGES * MAX_COUNT_W;

   // Returns the width-bit field for stage idx from a flattened, zero-extended
   // per-stage configuration vector (stage n at [n*width +: width]).
   function automatic logic [MAX_COUNT_W-1:0] count_field(
      input logic [CFG_FLAT_W-1:0]  flat,
      input logic [STAGE_IDX_W-1:0] idx,
      input int unsigned            width
   );
      logic [CFG_FLAT_W-1:0]  shifted;
      logic [MAX_COUNT_W-1:0] mask;
      shifted = flat >> (32'(idx) * width);
      mask    = (width >= MAX_COUNT_W) ? '1
              : ((MAX_COUNT_W'(1) << width) - MAX_COUNT_W'(1));
      return shifted[MAX_COUNT_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/hdlverifier_trig_timeout_counter.sv
// Per-stage timeout counter for the trigger sequencer. Counts enabled cycles,
// flags expiry on the cycle the count reaches the programmed limit and then
// restarts from zero. A limit of zero disables expiry.
module hdlverifier_trig_timeout_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic             expire
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign expire = enable & (limit != '0) & ((cnt_q + WIDTH'(1)) == limit);

   // Next count: clear wins, otherwise advance on enable and wrap on expiry.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = expire ? '0 : (cnt_q + WIDTH'(1));
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hdlverifier_trigger_sequencer.sv
// Multi-stage trigger sequencer. Walks up to NUM_STAGES programmable stages,
// each completing after its programmed number of stage_hit pulses, and emits
// a one-cycle trigger one clock after the final stage completes.
// Optional feature macro: HDLV_TRIG_SEQ_TIMEOUT_EN builds the per-stage
// timeout (stages after 0) and the sticky seq_reset flag; without it stages
// wait indefinitely and seq_reset is tied low.
module hdlverifier_trigger_sequencer
   import hdlverifier_trigger_pkg::*;
#(
   parameter int NUM_STAGES    = 4,
   parameter int COUNT_WIDTH   = 8,
   parameter int TIMEOUT_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              clk_enable,
   input  logic                              start,
   input  logic [NUM_STAGES-1:0]             stage_hit,
   input  logic [3:0]                        cfg_last_stage,
   input  logic [NUM_STAGES*COUNT_WIDTH-1:0] cfg_count,
   input  logic [NUM_STAGES-1:0]             cfg_consecutive,
   input  logic [TIMEOUT_WIDTH-1:0]          cfg_timeout,
   output logic                              trigger,
   output logic [3:0]                        current_stage,
   output logic [3:0]                        stage_reset,
   output logic                              seq_reset,
   output logic                              armed
);

   localparam logic [STAGE_IDX_W-1:0] TOP_STAGE = STAGE_IDX_W'(NUM_STAGES - 1);

   seq_state_t             state_q, state_d;
   logic [STAGE_IDX_W-1:0] stage_q, stage_d;
   logic [STAGE_IDX_W-1:0] stage_reset_q, stage_reset_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   trigger_q, trigger_d;
   logic                   start_d1_q, start_d1_d;

   logic [STAGE_IDX_W-1:0] last_stage;
   logic [CFG_FLAT_W-1:0]  cfg_count_ext;
   logic [COUNT_WIDTH-1:0] tgt_raw;
   logic [COUNT_WIDTH-1:0] tgt;
   logic [COUNT_WIDTH-1:0] cnt_inc;
   logic                   arm_evt;
   logic                   hit_s;
   logic                   cons_s;
   logic                   eval_en;
   logic                   complete;
   logic                   tmo_expire;

   // Edge detect on start runs every clock so a held start never re-arms.
   assign start_d1_d = start;
   assign arm_evt    = start & ~start_d1_q;

   // A final-stage index beyond the implemented stages is clamped.
   assign last_stage = (cfg_last_stage > TOP_STAGE) ? TOP_STAGE : cfg_last_stage;

   // A programmed target of zero behaves as a single-hit stage.
   assign cfg_count_ext = CFG_FLAT_W'(cfg_count);
   assign tgt_raw       = COUNT_WIDTH'(count_field(cfg_count_ext, stage_q, COUNT_WIDTH));
   assign tgt           = (tgt_raw == '0) ? COUNT_WIDTH'(1) : tgt_raw;
   assign cnt_inc       = cnt_q + COUNT_WIDTH'(1);

   // Select the hit and consecutive-mode bits of the stage under evaluation.
   always_comb begin
      hit_s  = 1'b0;
      cons_s = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (stage_q == STAGE_IDX_W'(i)) begin
            hit_s  = stage_hit[i];
            cons_s = cfg_consecutive[i];
         end
      end
   end

   // Arming outranks evaluation, so a same-cycle arm suppresses completion.
   assign eval_en  = (state_q == ST_ARMED) & clk_enable & ~arm_evt;
   assign complete = eval_en & hit_s & (cnt_inc == tgt);

`ifdef HDLV_TRIG_SEQ_TIMEOUT_EN
   logic seq_reset_q, seq_reset_d;
   logic tmo_enable;
   logic tmo_clear;

   // Stage 0 waits indefinitely; later stages time out unless they complete.
   assign tmo_enable = eval_en & ~complete & (stage_q != '0);
   assign tmo_clear  = arm_evt | complete;

   hdlverifier_trig_timeout_counter #(
      .WIDTH (TIMEOUT_WIDTH)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmo_clear),
      .enable (tmo_enable),
      .limit  (cfg_timeout),
      .expire (tmo_expire)
   );

   // Sticky timeout flag, cleared only by the next arm.
   always_comb begin
      seq_reset_d = seq_reset_q;
      if (arm_evt) begin
         seq_reset_d = 1'b0;
      end else if (tmo_expire) begin
         seq_reset_d = 1'b1;
      end
   end

   // Timeout flag register.
   always_ff @(posedge clk) begin
      if (reset) begin
         seq_reset_q <= 1'b0;
      end else begin
         seq_reset_q <= seq_reset_d;
      end
   end

   assign seq_reset = seq_reset_q;
`else
   logic unused_cfg_timeout;
   assign unused_cfg_timeout = ^cfg_timeout;
   assign tmo_expire         = 1'b0;
   assign seq_reset          = 1'b0;
`endif

   // Next-state and sequencing: arm, per-stage hit counting, advance, trigger.
   always_comb begin
      state_d       = state_q;
      stage_d       = stage_q;
      cnt_d         = cnt_q;
      stage_reset_d = stage_reset_q;
      trigger_d     = 1'b0;

      if (arm_evt) begin
         state_d       = ST_ARMED;
         stage_d       = '0;
         cnt_d         = '0;
         stage_reset_d = '0;
      end else if (eval_en) begin
         if (complete) begin
            cnt_d = '0;
            if (stage_q < last_stage) begin
               stage_d = stage_q + STAGE_IDX_W'(1);
            end else begin
               trigger_d = 1'b1;
               state_d   = ST_DONE;
            end
         end else if (hit_s) begin
            cnt_d = cnt_inc;
         end else if (cons_s && (cnt_q != '0)) begin
            cnt_d         = '0;
            stage_reset_d = stage_q;
         end

         if (tmo_expire) begin
            stage_d = '0;
            cnt_d   = '0;
         end
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         stage_q       <= '0;
         cnt_q         <= '0;
         stage_reset_q <= '0;
         trigger_q     <= 1'b0;
         start_d1_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         stage_q       <= stage_d;
         cnt_q         <= cnt_d;
         stage_reset_q <= stage_reset_d;
         trigger_q     <= trigger_d;
         start_d1_q    <= start_d1_d;
      end
   end

   assign trigger       = trigger_q;
   assign current_stage = stage_q;
   assign stage_reset   = stage_reset_q;
   assign armed         = (state_q == ST_ARMED);

endmodule

// File: tb/tb_hdlverifier_trigger_sequencer.sv
// Directed bench for the multi-stage trigger sequencer (4 stages, 8-bit
// counts, 16-bit timeout).
module tb_hdlverifier_trigger_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic        start;
   logic [3:0]  stage_hit;
   logic [3:0]  cfg_last_stage;
   logic [31:0] cfg_count;
   logic [3:0]  cfg_consecutive;
   logic [15:0] cfg_timeout;
   logic        trigger;
   logic [3:0]  current_stage;
   logic [3:0]  stage_reset;
   logic        seq_reset;
   logic        armed;

   int checks   = 0;
   int failures = 0;

   hdlverifier_trigger_sequencer #(
      .NUM_STAGES    (4),
      .COUNT_WIDTH   (8),
      .TIMEOUT_WIDTH (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .clk_enable      (clk_enable),
      .start           (start),
      .stage_hit       (stage_hit),
      .cfg_last_stage  (cfg_last_stage),
      .cfg_count       (cfg_count),
      .cfg_consecutive (cfg_consecutive),
      .cfg_timeout     (cfg_timeout),
      .trigger         (trigger),
      .current_stage   (current_stage),
      .stage_reset     (stage_reset),
      .seq_reset       (seq_reset),
      .armed           (armed)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Rising edge on start, leaving start low afterwards.
   task automatic arm();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; clk_enable = 1'b1; start = 1'b0; stage_hit = '0;
      cfg_last_stage = '0; cfg_count = '0; cfg_consecutive = '0; cfg_timeout = '0;
      tick(); tick();
      checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL rst_trigger got %0d expected 0", trigger); end
      checks++; if (current_stage !== 4'd0) begin failures++; $display("FAIL rst_stage got %0d expected 0", current_stage); end
      checks++; if (stage_reset !== 4'd0) begin failures++; $display("FAIL rst_stage_reset got %0d expected 0", stage_reset); end
      checks++; if (seq_reset !== 1'b0) begin failures++; $display("FAIL rst_seq_reset got %0d expected 0", seq_reset); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL rst_armed got %0d expected 0", armed); end
      reset = 1'b0;
      tick();
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL idle_no_arm got %0d expected 0", armed); end
   endtask

   task automatic test_basic_sequence();
      cfg_last_stage = 4'd1; cfg_count = {8'd0, 8'd0, 8'd2, 8'd3}; cfg_consecutive = '0;
      arm();
      checks++; if (armed !== 1'b1) begin failures++; $display("FAIL basic_armed got %0d expected 1", armed); end
      stage_hit = 4'b0001; tick(); stage_hit = '0; tick();
      stage_hit = 4'b0001; tick(); stage_hit = '0; tick();
      checks++; if (current_stage !== 4'd0) begin failures++; $display("FAIL basic_stage_before got %0d expected 0", current_stage); end
      stage_hit = 4'b0001; tick(); stage_hit = '0;
      checks++; if (current_stage !== 4'd1) begin failures++; $display("FAIL basic_stage_adv got %0d expected 1", current_stage); end
      stage_hit = 4'b0010; tick(); stage_hit = '0; tick();
      checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL basic_early_trig got %0d expected 0", trigger); end
      stage_hit = 4'b0010; tick(); stage_hit = '0;
      checks++; if (trigger !== 1'b1) begin failures++; $display("FAIL basic_trigger got %0d expected 1", trigger); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL basic_done_armed got %0d expected 0", armed); end
      tick();
      checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL basic_one_pulse got %0d expected 0", trigger); end
      checks++; if (current_stage !== 4'd1) begin failures++; $display("FAIL basic_done_stage got %0d expected 1", current_stage); end
   endtask

   task automatic test_consecutive();
      logic [6:0] pat;
      pat = 7'b1111011;
      cfg_last_stage = 4'd1; cfg_count = {8'd0, 8'd0, 8'd2, 8'd4}; cfg_consecutive = 4'b0011;
      arm();
      for (int i = 0; i < 7; i++) begin
         stage_hit = {3'b000, pat[i]};
         tick();
         if (i == 2) begin
            checks++; if (stage_reset !== 4'd0) begin failures++; $display("FAIL cons_stage_reset0 got %0d expected 0", stage_reset); end
         end
         if (i == 5) begin
            checks++; if (current_stage !== 4'd0) begin failures++; $display("FAIL cons_no_adv got %0d expected 0", current_stage); end
         end
      end
      stage_hit = '0;
      checks++; if (current_stage !== 4'd1) begin failures++; $display("FAIL cons_adv got %0d expected 1", current_stage); end
      stage_hit = 4'b0010; tick(); stage_hit = '0; tick();
      checks++; if (stage_reset !== 4'd1) begin failures++; $display("FAIL cons_stage_reset1 got %0d expected 1", stage_reset); end
      checks++; if (current_stage !== 4'd1) begin failures++; $display("FAIL cons_hold_stage got %0d expected 1", current_stage); end
      stage_hit = 4'b0010; tick();
      checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL cons_early_trig got %0d expected 0", trigger); end
      tick(); stage_hit = '0;
      checks++; if (trigger !== 1'b1) begin failures++; $display("FAIL cons_trigger got %0d expected 1", trigger); end
      cfg_consecutive = '0;
   endtask

   task automatic test_timeout();
      cfg_last_stage = 4'd1; cfg_count = {8'd0, 8'd0, 8'd1, 8'd1}; cfg_timeout = 16'd5;
      arm();
      stage_hit = 4'b0001; tick(); stage_hit = '0;
      checks++; if (current_stage !== 4'd1) begin failures++; $display("FAIL tmo_enter got %0d expected 1", current_stage); end
      for (int i = 0; i < 4; i++) tick();
      checks++; if (current_stage !== 4'd1) begin failures++; $display("FAIL tmo_still_waiting got %0d expected 1", current_stage); end
      tick();
`ifdef HDLV_TRIG_SEQ_TIMEOUT_EN
      checks++; if (current_stage !== 4'd0) begin failures++; $display("FAIL tmo_back_to_0 got %0d expected 0", current_stage); end
      checks++; if (seq_reset !== 1'b1) begin failures++; $display("FAIL tmo_seq_reset got %0d expected 1", seq_reset); end
      arm();
      checks++; if (seq_reset !== 1'b0) begin failures++; $display("FAIL tmo_rearm_clear got %0d expected 0", seq_reset); end
`else
      for (int i = 0; i < 10; i++) tick();
      checks++; if (current_stage !== 4'd1) begin failures++; $display("FAIL notmo_wait got %0d expected 1", current_stage); end
      checks++; if (seq_reset !== 1'b0) begin failures++; $display("FAIL notmo_seq_reset got %0d expected 0", seq_reset); end
`endif
      cfg_timeout = '0;
   endtask

   task automatic test_clk_enable();
      cfg_last_stage = 4'd0; cfg_count = {8'd0, 8'd0, 8'd0, 8'd3};
      clk_enable = 1'b1;
      arm();
      for (int i = 0; i < 6; i++) begin
         clk_enable = (i % 2) == 1;
         stage_hit  = 4'b0001;
         tick();
         if (i == 4) begin
            checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL en_early_trig got %0d expected 0", trigger); end
            checks++; if (armed !== 1'b1) begin failures++; $display("FAIL en_armed got %0d expected 1", armed); end
         end
      end
      stage_hit = '0; clk_enable = 1'b1;
      checks++; if (trigger !== 1'b1) begin failures++; $display("FAIL en_trigger got %0d expected 1", trigger); end
   endtask

   task automatic test_rearm();
      cfg_last_stage = 4'd3; cfg_count = {8'd1, 8'd2, 8'd1, 8'd1};
      arm();
      stage_hit = 4'b0001; tick();
      stage_hit = 4'b0010; tick();
      stage_hit = 4'b0100; tick();
      stage_hit = '0;
      checks++; if (current_stage !== 4'd2) begin failures++; $display("FAIL rearm_mid got %0d expected 2", current_stage); end
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (current_stage !== 4'd0) begin failures++; $display("FAIL rearm_stage got %0d expected 0", current_stage); end
      checks++; if (armed !== 1'b1) begin failures++; $display("FAIL rearm_armed got %0d expected 1", armed); end
      cfg_count = {8'd1, 8'd1, 8'd1, 8'd2};
      stage_hit = 4'b0001; tick(); stage_hit = '0;
      arm();
      stage_hit = 4'b0001; tick(); stage_hit = '0;
      checks++; if (current_stage !== 4'd0) begin failures++; $display("FAIL rearm_cnt_clear got %0d expected 0", current_stage); end
      stage_hit = 4'b0001; tick(); stage_hit = '0;
      checks++; if (current_stage !== 4'd1) begin failures++; $display("FAIL rearm_cnt_adv got %0d expected 1", current_stage); end
   endtask

   task automatic test_reset_drops_trigger();
      cfg_last_stage = 4'd0; cfg_count = {8'd0, 8'd0, 8'd0, 8'd1};
      arm();
      stage_hit = 4'b0001; reset = 1'b1; tick();
      checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL rstmid_trigger got %0d expected 0", trigger); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL rstmid_armed got %0d expected 0", armed); end
      reset = 1'b0; stage_hit = '0; tick();
      checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL rstmid_late_trig got %0d expected 0", trigger); end
   endtask

   task automatic test_boundaries();
      cfg_last_stage = 4'd0; cfg_count = '0;
      arm();
      stage_hit = 4'b0001; tick(); stage_hit = '0;
      checks++; if (trigger !== 1'b1) begin failures++; $display("FAIL zero_count_trig got %0d expected 1", trigger); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL zero_count_done got %0d expected 0", armed); end
      cfg_last_stage = 4'd9; cfg_count = {8'd1, 8'd1, 8'd1, 8'd1};
      arm();
      stage_hit = 4'b0001; tick();
      stage_hit = 4'b0010; tick();
      stage_hit = 4'b0100; tick();
      stage_hit = '0;
      checks++; if (current_stage !== 4'd3) begin failures++; $display("FAIL clamp_stage got %0d expected 3", current_stage); end
      checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL clamp_early_trig got %0d expected 0", trigger); end
      stage_hit = 4'b1000; tick(); stage_hit = '0;
      checks++; if (trigger !== 1'b1) begin failures++; $display("FAIL clamp_trigger got %0d expected 1", trigger); end
      checks++; if (current_stage !== 4'd3) begin failures++; $display("FAIL clamp_done_stage got %0d expected 3", current_stage); end
   endtask

   initial begin
      test_reset();
      test_basic_sequence();
      test_consecutive();
      test_timeout();
      test_clk_enable();
      test_rearm();
      test_reset_drops_trigger();
      test_boundaries();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
